// File: rtl/spram_loader_pkg.sv
// Shared types for the spram front-end arbiter: FSM states, issue sources, download address width.
package spram_loader_pkg;
  localparam int DL_ADDR_W = 25;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_DL,
    SRC_CLR,
    SRC_CPU
  } src_t;
endpackage

// File: rtl/spram_loader_arb.sv
// Single-issue RAM front-end: reset clear, download writes and one CPU port; priority dl > clear > cpu.
// CPU ops ack 3 cycles after accept; cpu_rdy stays low while busy, downloading or a dl write is pending.
module spram_loader_arb
  import spram_loader_pkg::*;
#(
  parameter int data_width = 8,
  parameter int addr_width = 10,
  parameter logic [data_width-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  output logic                  cpu_rdy,
  input  logic                  cpu_we,
  input  logic [addr_width-1:0] cpu_addr,
  input  logic [data_width-1:0] cpu_din,
  output logic                  cpu_ack,
  output logic [data_width-1:0] cpu_dout,
  input  logic                  dl_active,
  input  logic                  dl_wr,
  input  logic [DL_ADDR_W-1:0]  dl_addr,
  input  logic [data_width-1:0] dl_data,
  output logic                  dl_overflow,
  output logic                  clear_done,
  output logic [addr_width-1:0] mem_address,
  output logic [data_width-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  mem_cs,
  input  logic [data_width-1:0] mem_q
);

  state_t                state, state_nxt;
  src_t                  src;
  logic [addr_width-1:0] clr_cnt;
  logic                  dl_pend;
  logic [addr_width-1:0] dl_hold_addr;
  logic [data_width-1:0] dl_hold_data;
  logic                  cpu_stage1, cpu_stage2;
  logic                  dl_in_range, dl_take, accept, cpu_busy, rdy_nxt;

  always_comb begin
    state_nxt   = state;
    src         = SRC_NONE;
    dl_in_range = (dl_addr[DL_ADDR_W-1:addr_width] == '0);
    dl_take     = dl_wr && dl_in_range;
    accept      = cpu_req && cpu_rdy;
    if (dl_pend) begin
      src = SRC_DL;
    end else if (state == CLEAR) begin
      // Clear holds its count while a download is underway.
      if (!dl_active) begin
        src = SRC_CLR;
        if (clr_cnt == '1) state_nxt = RUN;
      end
    end else if (accept) begin
      src = SRC_CPU;
    end
    // Busy covers the issue, RAM-read and ack-capture cycles of an accepted op.
    cpu_busy = accept || cpu_stage1 || cpu_stage2;
    rdy_nxt  = (state_nxt == RUN) && !dl_active && !dl_take && !cpu_busy;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      dl_pend      <= 1'b0;
      dl_hold_addr <= '0;
      dl_hold_data <= '0;
      dl_overflow  <= 1'b0;
      clear_done   <= 1'b0;
      cpu_stage1   <= 1'b0;
      cpu_stage2   <= 1'b0;
      cpu_rdy      <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_dout     <= '0;
      mem_wren     <= 1'b0;
      mem_cs       <= 1'b0;
      mem_address  <= '0;
      mem_data     <= '0;
    end else begin
      state      <= state_nxt;
      clear_done <= (state_nxt == RUN);
      if (src == SRC_CLR) clr_cnt <= clr_cnt + 1'b1;

      dl_pend <= dl_take;
      if (dl_take) begin
        dl_hold_addr <= dl_addr[addr_width-1:0];
        dl_hold_data <= dl_data;
      end
      if (dl_wr && !dl_in_range) dl_overflow <= 1'b1;

      mem_cs   <= (src != SRC_NONE);
      mem_wren <= (src == SRC_DL) || (src == SRC_CLR) || ((src == SRC_CPU) && cpu_we);
      case (src)
        SRC_DL: begin
          mem_address <= dl_hold_addr;
          mem_data    <= dl_hold_data;
        end
        SRC_CLR: begin
          mem_address <= clr_cnt;
          mem_data    <= CLEAR_VALUE;
        end
        SRC_CPU: begin
          mem_address <= cpu_addr;
          mem_data    <= cpu_din;
        end
        default: ;
      endcase

      // Write-through RAM means mem_q echoes write data, so one capture path serves both ops.
      cpu_stage1 <= (src == SRC_CPU);
      cpu_stage2 <= cpu_stage1;
      cpu_ack    <= cpu_stage2;
      if (cpu_stage2) cpu_dout <= mem_q;
      cpu_rdy <= rdy_nxt;
    end
  end

endmodule

// File: tb/tb_spram_loader_arb.sv
// Scoreboard bench for spram_loader_arb with a 1-cycle write-through RAM model.
module tb_spram_loader_arb;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [DW-1:0] CV = 8'hA5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic          cpu_rdy, cpu_ack;
  logic [DW-1:0] cpu_dout;
  logic          dl_active = 1'b0, dl_wr = 1'b0;
  logic [24:0]   dl_addr = '0;
  logic [DW-1:0] dl_data = '0;
  logic          dl_overflow, clear_done;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_q;
  logic          mem_wren, mem_cs;
  logic [DW-1:0] ram [2**AW];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {int cyc; int a; int d;} wr_t;
  typedef struct {int cyc; int d;} ack_t;
  wr_t  wr_q[$];
  ack_t ack_q[$];
  wr_t  ew;
  ack_t ea;

  spram_loader_arb #(.data_width(DW), .addr_width(AW), .CLEAR_VALUE(CV)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_rdy(cpu_rdy), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_overflow(dl_overflow), .clear_done(clear_done),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_cs(mem_cs), .mem_q(mem_q)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (mem_cs) begin
      if (mem_wren) begin
        ram[mem_address] <= mem_data;
        mem_q            <= mem_data;
      end else begin
        mem_q <= ram[mem_address];
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every RAM write and every ack must match the head of its queue, in the expected cycle.
  always @(negedge clock) begin
    if (mem_cs && mem_wren) begin
      chk("mem_wr_expected", int'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) begin
        ew = wr_q.pop_front();
        chk("mem_address", int'(mem_address), ew.a);
        chk("mem_data", int'(mem_data), ew.d);
        chk("mem_wr_cycle", cyc, ew.cyc);
      end
    end
    if (cpu_ack) begin
      chk("ack_expected", int'(ack_q.size() > 0), 1);
      if (ack_q.size() > 0) begin
        ea = ack_q.pop_front();
        chk("cpu_dout", int'(cpu_dout), ea.d);
        chk("cpu_ack_cycle", cyc, ea.cyc);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_clear(input int first, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) wr_q.push_back('{first + i - lo, i, int'(CV)});
  endtask

  task automatic wait_done();
    int t = 0;
    while (!clear_done && t < 200) begin
      tick();
      t++;
    end
    chk("clear_done_wait", int'(clear_done), 1);
  endtask

  task automatic cpu_op(input bit we, input int a, input int d, input int exp,
                        input bit dl_mid, input int dla, input int dld, input bit rst_mid);
    int t = 0;
    int acc;
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = AW'(a);
    cpu_din  = DW'(d);
    while (!cpu_rdy && t < 100) begin
      tick();
      t++;
    end
    chk("cpu_accept", int'(cpu_rdy), 1);
    if (!cpu_rdy) begin
      cpu_req = 1'b0;
    end else begin
      acc = cyc;
      if (we) wr_q.push_back('{acc + 1, a, d});
      if (!rst_mid) ack_q.push_back('{acc + 3, exp});
      if (dl_mid) wr_q.push_back('{acc + 3, dla, dld});
      for (int k = 1; k <= 3; k++) begin
        tick();
        if (k == 1) begin
          cpu_req = 1'b0;
          if (dl_mid) begin
            dl_active = 1'b1;
            dl_wr     = 1'b1;
            dl_addr   = 25'(dla);
            dl_data   = DW'(dld);
          end
        end
        if (k == 2) begin
          dl_wr = 1'b0;
          if (rst_mid) reset = 1'b1;
        end
        chk("cpu_rdy_busy", int'(cpu_rdy), 0);
      end
    end
  endtask

  initial begin
    int r;
    // Reset values
    tick(3);
    chk("rst_cpu_rdy", int'(cpu_rdy), 0);
    chk("rst_cpu_ack", int'(cpu_ack), 0);
    chk("rst_cpu_dout", int'(cpu_dout), 0);
    chk("rst_mem_wren", int'(mem_wren), 0);
    chk("rst_mem_cs", int'(mem_cs), 0);
    chk("rst_mem_address", int'(mem_address), 0);
    chk("rst_mem_data", int'(mem_data), 0);
    chk("rst_clear_done", int'(clear_done), 0);
    chk("rst_dl_overflow", int'(dl_overflow), 0);

    // Power-on clear: 16 back-to-back writes, clear_done and cpu_rdy with the last one
    r = cyc;
    push_clear(r + 1, 0, 15);
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("clear_done_early", int'(clear_done), 0);
    end
    chk("clear_done", int'(clear_done), 1);
    chk("cpu_rdy_after_clear", int'(cpu_rdy), 1);

    // CPU write then read back
    cpu_op(1'b1, 3, 'h5C, 'h5C, 1'b0, 0, 0, 1'b0);
    cpu_op(1'b0, 3, 0, 'h5C, 1'b0, 0, 0, 1'b0);

    // Download interleaved with clear, suspended at count 6
    reset = 1'b1;
    tick(2);
    chk("clear_done_reset", int'(clear_done), 0);
    r = cyc;
    push_clear(r + 1, 0, 5);
    wr_q.push_back('{r + 9, 2, 'h11});
    wr_q.push_back('{r + 11, 7, 'h22});
    push_clear(r + 12, 6, 15);
    reset = 1'b0;
    tick(6);
    dl_active = 1'b1;
    tick();
    dl_wr = 1'b1; dl_addr = 25'd2; dl_data = 8'h11;
    tick();
    dl_wr = 1'b0;
    tick();
    dl_wr = 1'b1; dl_addr = 25'd7; dl_data = 8'h22;
    tick();
    dl_wr = 1'b0;
    tick();
    dl_active = 1'b0;
    wait_done();
    cpu_op(1'b0, 2, 0, 'h11, 1'b0, 0, 0, 1'b0);
    cpu_op(1'b0, 7, 0, 'hA5, 1'b0, 0, 0, 1'b0);
    cpu_op(1'b0, 0, 0, 'hA5, 1'b0, 0, 0, 1'b0);
    cpu_op(1'b0, 15, 0, 'hA5, 1'b0, 0, 0, 1'b0);

    // Out-of-range download write is dropped and flagged
    dl_active = 1'b1;
    dl_wr = 1'b1; dl_addr = 25'h10; dl_data = 8'hFF;
    tick();
    dl_wr = 1'b0;
    tick();
    dl_active = 1'b0;
    tick();
    chk("dl_overflow_set", int'(dl_overflow), 1);

    // Download starting mid CPU read: read returns pre-download value
    cpu_op(1'b0, 9, 0, 'hA5, 1'b1, 9, 'h77, 1'b0);
    tick();
    chk("cpu_rdy_dl_active", int'(cpu_rdy), 0);
    dl_active = 1'b0;
    tick();
    chk("cpu_rdy_after_dl", int'(cpu_rdy), 1);
    cpu_op(1'b0, 9, 0, 'h77, 1'b0, 0, 0, 1'b0);
    chk("dl_overflow_sticky", int'(dl_overflow), 1);

    // Reset during a CPU read: no ack, clear restarts from 0
    cpu_op(1'b0, 5, 0, 0, 1'b0, 0, 0, 1'b1);
    chk("clear_done_mid_reset", int'(clear_done), 0);
    chk("dl_overflow_reset", int'(dl_overflow), 0);
    tick();
    r = cyc;
    push_clear(r + 1, 0, 15);
    reset = 1'b0;
    wait_done();
    tick(4);
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
